dctq_transpose_ctrl: RTL
========================

# dctq_transpose_ctrl

Ping-pong sequencer for the 8x64-bit dual-bank transpose buffer between the row-DCT and column-DCT stages of the DCTQ pipeline. It accepts 8 row words per block from the row stage and drives the buffer's write controls for one bank. At the same time it reads the other, previously filled bank column-wise, presenting a valid-tagged column stream to the column stage. It swaps banks at block boundaries and throttles the row stage when both banks are busy.

## Interface
- RD_LAT, 2: clocks from `ra` presented to column word valid on the buffer `do` output (buffer RAM read plus output register)
- clk  in  1  single system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  row stage presents a row word on the buffer `di` bus
- in_ready  out  1  controller accepts the row word this cycle
- rnw  out  1  bank select to buffer; 1 = bank1 written, bank2 read; 0 = reverse
- wa  out  3  write row address
- be  out  8  byte enables; 8'hFF on an accepted write, 8'h00 otherwise
- din_valid  out  1  write strobe = in_valid & in_ready
- ra  out  3  read column address
- col_valid  out  1  buffer `do` holds a valid column word this cycle
- col_idx  out  3  column index of the word under col_valid
- blk_last  out  1  with col_valid, marks column 7
- err  out  1  sticky protocol error (see Configuration)

## Operation
- Writer FSM W_FILL / W_HOLD; reader FSM R_IDLE / R_BUSY; 3-bit wr_ptr, rd_ptr.
- W_FILL: in_ready=1; each accepted word writes row wr_ptr (wa=wr_ptr), wr_ptr++ mod 8. Accepting row 7 → swap if reader is free (R_IDLE, or R_BUSY issuing ra=7 this cycle), else go W_HOLD.
- W_HOLD: in_ready=0, wa holds 0; swap on the cycle the reader issues ra=7; return to W_FILL.
- Swap: rnw toggles at the clock edge; reader enters R_BUSY with rd_ptr=0; wr_ptr=0.
- R_BUSY: ra=rd_ptr, rd_ptr++ each cycle, one column per cycle, no stall; after ra=7 go R_IDLE unless a new swap occurs the same edge.
- R_IDLE: ra=0, no read tagging.
- col_valid/col_idx/blk_last: read-issue flag and rd_ptr delayed RD_LAT clocks through a shift pipe.
- rnw changes only at swaps, so the buffer's internal 1-cycle rnw delay selects the correct bank for every issued read.
- Partial block (input stops mid-block): controller waits in W_FILL indefinitely; no flush.
- Column stage has no backpressure; it must accept one word per cycle while col_valid=1.

## Timing
- Reset values: in_ready=0 while reset_n low, 1 from first clk after release; rnw=1, wa=0, ra=0, be=0, din_valid=0, col_valid=0, col_idx=0, blk_last=0, err=0. Both FSMs idle/fill, pointers 0, pipe cleared.
- Write: combinational from in_valid in the accept cycle (din_valid, be), registered wa.
- Swap latency: 8th row accepted at edge t → rnw toggled and ra=0 issued in cycle t+1 → col_valid first high at t+1+RD_LAT.
- Sustained throughput: 1 row in, 1 column out per clock, no bubbles when in_valid is continuous; fill-to-first-column latency 8+1+RD_LAT clocks.
- Reset mid-operation: immediate abort, all state cleared, in-flight columns discarded; buffer contents ignored.

## Configuration
- DCTQ_TRANSPOSE_ERR_EN defined: err sets on in_valid=1 while in_ready=0 after reset (row stage overrun), clears only on reset.
- Not defined: err tied 0, no detection logic; port retained.

## Structure
- Shared package dctq_pkg: BLK_DIM=8, ADDR_W=3, WORD_W=64, BE_ALL=8'hFF, writer/reader state encodings.
- One sub-module dctq_valid_pipe: RD_LAT-deep shift pipe carrying {valid, idx, last}, asynchronously cleared.
- Controller instantiates the pipe; the transpose buffer is instantiated by the parent, not inside this block.

## Test plan
- Reset then in_valid held 1 for 8 clocks → wa 0..7, be=8'hFF each, rnw 1→0 after 8th, col_valid high 8 clocks from 1+RD_LAT later, col_idx 0..7, blk_last on 7.
- 32 continuous rows (4 blocks) → rnw toggles every 8 clocks, in_ready never drops, 32 col_valid with no gaps; data equals transposed input.
- Two blocks back-to-back, then stall row stage after 3 rows of block 3 → writer stays in W_FILL, wr_ptr=3, reader drains block 2 then idles, no spurious col_valid.
- Drive in_valid while in_ready=0 (during reset release cycle) → err=1 with DCTQ_TRANSPOSE_ERR_EN, err=0 without, err stays until reset.
- Assert reset_n low mid-read (col_idx=4) → all outputs at reset values same cycle; after release, new block produces col_idx starting at 0.
- Random in_valid gaps over 20 blocks → scoreboard matches each 8x8 block transposed, blk_last count = 20.

Source files
------------

// File: rtl/dctq_pkg.sv
// ---------------------------------------------------------------------------
// dctq_pkg
// Shared constants and state encodings for the DCTQ transpose sequencer.
//   BLK_DIM  : rows (and columns) per 8x8 block
//   ADDR_W   : row/column address width into the transpose buffer
//   WORD_W   : buffer word width (one row or one column of 8 bytes)
//   RD_LAT   : clocks from read address to valid column word on buffer 'do'
//   BE_ALL   : byte-enable pattern for a full-word row write
//   LAST_IDX : address of the final row/column in a block
// ---------------------------------------------------------------------------
package dctq_pkg;

  localparam int BLK_DIM = 8;
  localparam int ADDR_W  = 3;
  localparam int WORD_W  = 64;
  localparam int RD_LAT  = 2;

  localparam logic [WORD_W/8-1:0] BE_ALL   = 8'hFF;
  localparam logic [ADDR_W-1:0]   LAST_IDX = ADDR_W'(BLK_DIM - 1);

  // Writer: filling a bank from the row stage, or holding a full bank
  // until the reader releases the other one.
  typedef enum logic {
    W_FILL = 1'b0,
    W_HOLD = 1'b1
  } wr_state_t;

  // Reader: idle, or streaming the eight columns of the filled bank.
  typedef enum logic {
    R_IDLE = 1'b0,
    R_BUSY = 1'b1
  } rd_state_t;

endpackage

// File: rtl/dctq_valid_pipe.sv
// ---------------------------------------------------------------------------
// dctq_valid_pipe
// Fixed-depth shift pipe that carries read-issue tags alongside the
// transpose buffer's read latency, so the tag emerges with the data word.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low clear of every stage
//   i_d     : tag entering the pipe this cycle
//   o_q     : tag delayed by DEPTH clocks
// ---------------------------------------------------------------------------
module dctq_valid_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Plain shift register; a reset drops every in-flight tag so no stale
  // column is ever reported after an abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/dctq_transpose_ctrl.sv
// ---------------------------------------------------------------------------
// dctq_transpose_ctrl
// Ping-pong sequencer for the 8x64-bit dual-bank transpose buffer between
// the row-DCT and column-DCT stages. One bank is filled row-wise from the
// row stage while the other is read column-wise to the column stage; the
// banks swap at block boundaries.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   in_valid     : row stage presents a row word on the buffer di bus
//   in_ready     : row word is accepted this cycle
//   rnw          : bank select (1 = bank1 written / bank2 read)
//   wa, be       : write row address and byte enables
//   din_valid    : write strobe (in_valid & in_ready)
//   ra           : read column address
//   col_valid    : buffer do holds a valid column word
//   col_idx      : column index of that word
//   blk_last     : marks column 7 of a block
//   err          : sticky row-stage overrun flag
// Build option:
//   DCTQ_TRANSPOSE_ERR_EN : when defined, err latches on in_valid while
//                           in_ready is low; otherwise err is tied low.
// ---------------------------------------------------------------------------
module dctq_transpose_ctrl
  import dctq_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  rnw,
  output logic [ADDR_W-1:0]     wa,
  output logic [WORD_W/8-1:0]   be,
  output logic                  din_valid,
  output logic [ADDR_W-1:0]     ra,
  output logic                  col_valid,
  output logic [ADDR_W-1:0]     col_idx,
  output logic                  blk_last,
  output logic                  err
);

  localparam int TAG_W = ADDR_W + 2;

  wr_state_t         r_wr_state;
  rd_state_t         r_rd_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_in_ready;
  logic              r_rnw;

  logic              w_accept;
  logic              w_rd_issue;
  logic              w_rd_last;
  logic              w_rd_free;
  logic              w_swap;
  logic [TAG_W-1:0]  w_tag_d;
  logic [TAG_W-1:0]  w_tag_q;

  // The reader is free for a new block either when idle or on the very
  // cycle it issues the last column, which is what lets back-to-back
  // blocks stream without a bubble.
  assign w_accept   = in_valid & r_in_ready;
  assign w_rd_issue = (r_rd_state == R_BUSY);
  assign w_rd_last  = w_rd_issue && (r_rd_ptr == LAST_IDX);
  assign w_rd_free  = (r_rd_state == R_IDLE) || w_rd_last;
  assign w_swap     = ((r_wr_state == W_FILL) && w_accept && (r_wr_ptr == LAST_IDX) && w_rd_free)
                   || ((r_wr_state == W_HOLD) && w_rd_last);

  // Writer FSM. in_ready is a register so it stays low through reset and
  // the first edge after release. The pointer wraps to 0 after row 7, so
  // it already holds 0 while waiting in W_HOLD and after a swap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_state <= W_FILL;
      r_wr_ptr   <= '0;
      r_in_ready <= 1'b0;
      r_rnw      <= 1'b1;
    end else begin
      case (r_wr_state)
        W_FILL: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_wr_ptr == LAST_IDX) begin
              if (w_rd_free) begin
                r_rnw <= ~r_rnw;
              end else begin
                r_wr_state <= W_HOLD;
                r_in_ready <= 1'b0;
              end
            end
          end
        end
        W_HOLD: begin
          if (w_rd_last) begin
            r_rnw      <= ~r_rnw;
            r_wr_state <= W_FILL;
            r_in_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  // Reader FSM: one column per clock with no stall. Its pointer also wraps
  // to 0 after column 7, which is the start column of any block that swaps
  // in on that same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_state <= R_IDLE;
      r_rd_ptr   <= '0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          r_rd_ptr <= '0;
          if (w_swap) begin
            r_rd_state <= R_BUSY;
          end
        end
        R_BUSY: begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          if (w_rd_last && !w_swap) begin
            r_rd_state <= R_IDLE;
          end
        end
      endcase
    end
  end

  // Tag each issued read so it lines up with the buffer output word.
  assign w_tag_d = {w_rd_issue, r_rd_ptr, w_rd_last};

  dctq_valid_pipe #(
    .DEPTH (RD_LAT),
    .WIDTH (TAG_W)
  ) u_valid_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (w_tag_d),
    .o_q     (w_tag_q)
  );

  assign {col_valid, col_idx, blk_last} = w_tag_q;

  assign in_ready  = r_in_ready;
  assign rnw       = r_rnw;
  assign wa        = r_wr_ptr;
  assign ra        = r_rd_ptr;
  assign din_valid = w_accept;
  assign be        = w_accept ? BE_ALL : '0;

`ifdef DCTQ_TRANSPOSE_ERR_EN
  logic r_err;

  // Overrun detector: any row offered while the controller is not ready
  // (including the release cycle after reset) latches until the next reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (in_valid && !r_in_ready) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
